uart_rx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_sync_2ff.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame
// parameters used by the receiver, transmitter and baud generator, and
// a helper that sizes the oversampling tick counter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICK    = 16;

  // Width needed to count 0..max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if ($clog2(m) < 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Both flops
// reset to 1 so an idle-high serial line is not mistaken for a start bit
// on the cycles right after reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronization into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 1 start bit, DATA_BITS data bits LSB-first,
// 1 stop bit, no parity. Bit timing is derived from an external
// oversampling strobe; data bits are sampled at mid-bit.
//
// Output handshake: rx_done_tick is a one-cycle valid strobe with no
// ready. dout is stable from the rx_done_tick cycle until the next good
// frame, so the consumer may capture it on the strobe or any time later
// before the next strobe. frame_err is a one-cycle strobe on a low stop
// bit and never coincides with rx_done_tick; dout is not touched then.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICK    = DEF_SB_TICK
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 busy,
  output logic [1:0]           state_dbg_o
);

  localparam int CNT_W = cnt_width(OVERSAMPLE, SB_TICK);
  localparam int BIT_W = ($clog2(DATA_BITS) < 1) ? 1 : $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] OS_M1    = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] SB_M1    = CNT_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q,  state_d;
  logic [CNT_W-1:0]     s_cnt_q,  s_cnt_d;
  logic [BIT_W-1:0]     n_cnt_q,  n_cnt_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] dout_q,   dout_d;
  logic                 done_q,   done_d;
  logic                 err_q,    err_d;
  // Set after a framing error so a line held low (break) is not
  // re-framed; cleared once the line is seen high again.
  logic                 brk_q,    brk_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // State, counters, data and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      brk_q   <= brk_d;
    end
  end

  // Next-state logic: start qualification, mid-bit sampling, stop check.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    brk_d   = brk_q;

    unique case (state_q)
      IDLE: begin
        if (rx_s) begin
          brk_d = 1'b0;
        end else if (!brk_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == HALF_M1) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == OS_M1) begin
            s_cnt_d = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (n_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SB_M1) begin
            state_d = IDLE;
            if (rx_s) begin
              dout_d = shift_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
              brk_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = err_q;
  assign busy         = (state_q != IDLE);
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios followed by randomized
// frames. Expected outcomes are queued when a frame is issued and popped
// by an independent monitor whenever the receiver strobes an output.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int OS = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          s_tick;
  logic          rx;
  logic [DW-1:0] dout;
  logic          rx_done_tick;
  logic          frame_err;
  logic          busy;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(DW), .OVERSAMPLE(OS), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy),
    .state_dbg_o  (state_dbg)
  );

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Oversampling strobe: high one clk in every tick_div clks.
  int tick_div = 1;
  int tick_ph  = 0;
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) begin
        s_tick = 1'b1;
      end else begin
        tick_ph = (tick_ph + 1) % tick_div;
        s_tick  = (tick_ph == 0);
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Entry: {is_frame_err, dout value the receiver must present}.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_dout = '0;
  int n_checks = 0;
  int n_pass   = 0;
  int last_evt_cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every strobe must match the oldest expected outcome.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset && (rx_done_tick || frame_err)) begin
      check("pulse_exclusive", {31'd0, rx_done_tick & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_done_tick, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, frame_err}, {31'd0, e[DW]});
        check("dout_value", {24'd0, dout}, {24'd0, e[DW-1:0]});
        if (rx_done_tick) check("busy_at_done", {31'd0, busy}, 32'd0);
        last_evt_cycle = cycle;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok);
    int bp;
    bp = OS * tick_div;
    if (stop_ok) begin
      model_dout = d;
      exp_q.push_back({1'b0, d});
    end else begin
      exp_q.push_back({1'b1, model_dout});
    end
    hold(1'b0, bp);
    for (int i = 0; i < DW; i++) hold(d[i], bp);
    hold(stop_ok, bp);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int t_start, lat1, lat6;

  initial begin
    logic [DW-1:0] rd;
    bit            ok;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_dout",  {24'd0, dout}, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_done",  {31'd0, rx_done_tick}, 32'd0);
    check("reset_err",   {31'd0, frame_err}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, {30'd0, IDLE});
    reset = 1'b0;
    hold(1'b1, 20);

    // 1. good frame
    t_start = cycle;
    send_frame(8'hA5, 1'b1);
    drain();
    lat1 = last_evt_cycle - t_start;
    check("s1_dout", {24'd0, dout}, 32'h0000_00A5);
    hold(1'b1, 20);

    // 2. back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain();
    hold(1'b1, 20);

    // 3. glitch rejection
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("s3_busy", {31'd0, busy}, 32'd0);
    check("s3_dout", {24'd0, dout}, {24'd0, model_dout});

    // 4. frame error keeps dout
    send_frame(8'h3C, 1'b0);
    hold(1'b1, OS);
    drain();
    check("s4_dout", {24'd0, dout}, 32'h0000_00FF);
    hold(1'b1, 20);

    // 5. reset during data bit 3 of 0x81
    hold(1'b0, OS);
    hold(1'b1, OS);
    hold(1'b0, OS);
    hold(1'b0, OS);
    hold(1'b0, OS / 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx    = 1'b1;
    model_dout = '0;
    check("s5_dout", {24'd0, dout}, 32'd0);
    check("s5_busy", {31'd0, busy}, 32'd0);
    hold(1'b1, 12 * OS);
    send_frame(8'h5A, 1'b1);
    drain();
    check("s5_dout_after", {24'd0, dout}, 32'h0000_005A);
    hold(1'b1, 20);

    // 6. sparse ticks
    tick_div = 4;
    hold(1'b1, 8);
    t_start = cycle;
    send_frame(8'h96, 1'b1);
    drain();
    lat6 = last_evt_cycle - t_start;
    check("s6_dout", {24'd0, dout}, 32'h0000_0096);
    check("s6_latency_ratio", {31'd0, (lat6 >= 3 * lat1) && (lat6 <= 5 * lat1)}, 32'd1);
    hold(1'b1, 20);

    // Randomized frames: random data, tick density, stop bit and gaps.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    tick_div = 1;
        2:       tick_div = 2;
        default: tick_div = 4;
      endcase
      hold(1'b1, 8);
      rd = DW'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(rd, ok);
      if (!ok) hold(1'b1, OS * tick_div);
      else     hold(1'b1, $urandom_range(0, 20));
    end
    drain();
    check("final_dout", {24'd0, dout}, {24'd0, model_dout});
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
